pe_conv_window_gen_conv1: RTL and testbench

- Upstream feeder of the conv1 MAC controller/PE.
- Accepts the raster-order input feature map, one pixel per handshake with all channels packed, and buffers rows.
- Emits zero-padded, strided K×K windows in output raster order.
- out_valid drives the controller's en/buffer_valid; the controller's pe_ready drives out_ready.

---
 rtl/pe_conv_window_gen_conv1_if.sv | 35 +++
 rtl/pe_conv_window_gen_conv1.sv | 176 +++++++++++++++++
 tb/tb_pe_conv_window_gen_conv1.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_conv_window_gen_conv1_if.sv
// rtl/pe_conv_window_gen_conv1_if.sv - Pixel-in / window-out handshake bundle of the conv1 window generator.
interface pe_conv_window_gen_conv1_if #(
  parameter int pIN_CHANNEL   = 3,
  parameter int pDATA_WIDTH   = 8,
  parameter int pKERNEL_SIZE  = 3,
  parameter int pINPUT_WIDTH  = 224,
  parameter int pINPUT_HEIGHT = 224,
  parameter int pPADDING      = 1,
  parameter int pSTRIDE       = 2
);
  localparam int OW    = (pINPUT_WIDTH - pKERNEL_SIZE + 2 * pPADDING) / pSTRIDE + 1;
  localparam int OH    = (pINPUT_HEIGHT - pKERNEL_SIZE + 2 * pPADDING) / pSTRIDE + 1;
  localparam int ROW_W = (OH > 1) ? $clog2(OH) : 1;
  localparam int COL_W = (OW > 1) ? $clog2(OW) : 1;

  logic [pIN_CHANNEL*pDATA_WIDTH-1:0]                           in_data;
  logic                                                         in_valid;
  logic                                                         in_ready;
  logic [pKERNEL_SIZE*pKERNEL_SIZE*pIN_CHANNEL*pDATA_WIDTH-1:0] out_window;
  logic                                                         out_valid;
  logic                                                         out_ready;
  logic [ROW_W-1:0]                                             out_row;
  logic [COL_W-1:0]                                             out_col;
  logic                                                         done;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_window, out_valid, out_row, out_col, done
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_window, out_valid, out_row, out_col, done
  );
endinterface

// File: rtl/pe_conv_window_gen_conv1.sv
// rtl/pe_conv_window_gen_conv1.sv - Row-buffered, zero-padded, strided KxK window generator feeding the conv1 PE.
module pe_conv_window_gen_conv1 #(
  parameter int                     pIN_CHANNEL   = 3,
  parameter int                     pDATA_WIDTH   = 8,
  parameter int                     pKERNEL_SIZE  = 3,
  parameter int                     pINPUT_WIDTH  = 224,
  parameter int                     pINPUT_HEIGHT = 224,
  parameter int                     pPADDING      = 1,
  parameter int                     pSTRIDE       = 2,
  parameter logic [pDATA_WIDTH-1:0] pPAD_VALUE    = '0,
  parameter int                     pROW_BUF      = pKERNEL_SIZE + pSTRIDE
) (
  input logic                       clk,
  input logic                       rst,
  pe_conv_window_gen_conv1_if.slave bus
);
  localparam int K     = pKERNEL_SIZE;
  localparam int NB    = pROW_BUF;
  localparam int PIX_W = pIN_CHANNEL * pDATA_WIDTH;
  localparam int OW    = (pINPUT_WIDTH - K + 2 * pPADDING) / pSTRIDE + 1;
  localparam int OH    = (pINPUT_HEIGHT - K + 2 * pPADDING) / pSTRIDE + 1;
  localparam int ROW_W = (OH > 1) ? $clog2(OH) : 1;
  localparam int COL_W = (OW > 1) ? $clog2(OW) : 1;
  localparam int XW    = (pINPUT_WIDTH > 1) ? $clog2(pINPUT_WIDTH) : 1;
  localparam int YW    = $clog2(pINPUT_HEIGHT + 1);
  localparam int SW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW    = (K > 1) ? $clog2(K) : 1;
  // Slot holding virtual row -P, so slot(row) = (BASE0 + row + P) mod NB.
  localparam int BASE0 = (NB - (pPADDING % NB)) % NB;
  localparam logic [PIX_W-1:0] PAD_PIX = {pIN_CHANNEL{pPAD_VALUE}};

  typedef enum logic [1:0] {IDLE, LOAD, PRESENT, DONE} state_t;

  state_t state, state_nxt;

  logic [PIX_W-1:0]   line_mem [NB][pINPUT_WIDTH];
  logic [XW-1:0]      in_col;
  logic [YW-1:0]      in_row;
  logic [SW-1:0]      wr_slot;
  logic [ROW_W-1:0]   oy;
  logic [COL_W-1:0]   ox;
  logic [SW-1:0]      base_slot;
  logic [SW-1:0]      base_slot_nxt;
  logic [LW-1:0]      ld_cnt;
  logic [K*PIX_W-1:0] col_pix;
  logic [K*K*PIX_W-1:0] window_q;
  logic               in_ready;
  logic               in_fire;
  logic               out_fire;
  logic               eligible;
  logic               last_col;
  logic               last_win;
  int                 lo_row;
  int                 hi_row;

  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = (state == PRESENT) && bus.out_ready;
  assign last_col = (ox == COL_W'(OW - 1));
  assign last_win = last_col && (oy == ROW_W'(OH - 1));

  // Rows still needed by the current output row bound how far input may run ahead.
  always_comb begin
    lo_row = int'(oy) * pSTRIDE - pPADDING;
    if (lo_row < 0) lo_row = 0;
    hi_row = int'(oy) * pSTRIDE - pPADDING + K - 1;
    if (hi_row > pINPUT_HEIGHT - 1) hi_row = pINPUT_HEIGHT - 1;
    eligible = (int'(in_row) > hi_row);
    in_ready = !rst && (int'(in_row) < pINPUT_HEIGHT) && (int'(in_row) < lo_row + NB);
  end

  always_comb begin
    int bs;
    bs = int'(base_slot) + pSTRIDE;
    if (bs >= NB) bs = bs - NB;
    base_slot_nxt = SW'(bs);
  end

  always_ff @(posedge clk) begin
    if (in_fire) line_mem[wr_slot][in_col] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst || state == DONE) begin
      in_col  <= '0;
      in_row  <= '0;
      wr_slot <= '0;
    end else if (in_fire) begin
      if (in_col == XW'(pINPUT_WIDTH - 1)) begin
        in_col  <= '0;
        in_row  <= in_row + 1'b1;
        wr_slot <= (wr_slot == SW'(NB - 1)) ? '0 : wr_slot + 1'b1;
      end else begin
        in_col <= in_col + 1'b1;
      end
    end
  end

  // Column ld_cnt of the current window, one pixel per kernel row, padded outside the frame.
  always_comb begin
    int col_x;
    int row_y;
    int slot_i;
    col_pix = '0;
    row_y   = 0;
    slot_i  = 0;
    col_x   = int'(ox) * pSTRIDE - pPADDING + int'(ld_cnt);
    for (int ky = 0; ky < K; ky++) begin
      row_y  = int'(oy) * pSTRIDE - pPADDING + ky;
      slot_i = int'(base_slot) + ky;
      if (slot_i >= NB) slot_i = slot_i - NB;
      if (row_y < 0 || row_y >= pINPUT_HEIGHT || col_x < 0 || col_x >= pINPUT_WIDTH)
        col_pix[ky*PIX_W +: PIX_W] = PAD_PIX;
      else
        col_pix[ky*PIX_W +: PIX_W] = line_mem[SW'(slot_i)][XW'(col_x)];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (eligible) state_nxt = LOAD;
      LOAD:    if (ld_cnt == LW'(K - 1)) state_nxt = PRESENT;
      PRESENT: if (out_fire) state_nxt = last_win ? DONE : IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oy        <= '0;
      ox        <= '0;
      base_slot <= SW'(BASE0);
      ld_cnt    <= '0;
      window_q  <= '0;
    end else begin
      case (state)
        LOAD: begin
          for (int ky = 0; ky < K; ky++)
            window_q[(ky*K + int'(ld_cnt))*PIX_W +: PIX_W] <= col_pix[ky*PIX_W +: PIX_W];
          ld_cnt <= (ld_cnt == LW'(K - 1)) ? '0 : ld_cnt + 1'b1;
        end
        PRESENT: begin
          if (out_fire && !last_win) begin
            if (last_col) begin
              ox        <= '0;
              oy        <= oy + 1'b1;
              base_slot <= base_slot_nxt;
            end else begin
              ox <= ox + 1'b1;
            end
          end
        end
        DONE: begin
          oy        <= '0;
          ox        <= '0;
          base_slot <= SW'(BASE0);
          ld_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state == PRESENT);
  assign bus.out_window = window_q;
  assign bus.out_row    = oy;
  assign bus.out_col    = ox;
  assign bus.done       = (state == DONE);
endmodule

// File: tb/tb_pe_conv_window_gen_conv1.sv
// tb/tb_pe_conv_window_gen_conv1.sv - Self-checking bench for the conv1 window generator (4x4 C=1 and 8x8 C=3 instances).
module tb_pe_conv_window_gen_conv1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_conv_window_gen_conv1_if #(.pIN_CHANNEL(1), .pDATA_WIDTH(8), .pKERNEL_SIZE(3),
    .pINPUT_WIDTH(4), .pINPUT_HEIGHT(4), .pPADDING(1), .pSTRIDE(2)) ifa ();
  pe_conv_window_gen_conv1_if #(.pIN_CHANNEL(3), .pDATA_WIDTH(8), .pKERNEL_SIZE(3),
    .pINPUT_WIDTH(8), .pINPUT_HEIGHT(8), .pPADDING(1), .pSTRIDE(2)) ifb ();

  pe_conv_window_gen_conv1 #(.pIN_CHANNEL(1), .pDATA_WIDTH(8), .pKERNEL_SIZE(3),
    .pINPUT_WIDTH(4), .pINPUT_HEIGHT(4), .pPADDING(1), .pSTRIDE(2), .pPAD_VALUE(8'h00))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pe_conv_window_gen_conv1 #(.pIN_CHANNEL(3), .pDATA_WIDTH(8), .pKERNEL_SIZE(3),
    .pINPUT_WIDTH(8), .pINPUT_HEIGHT(8), .pPADDING(1), .pSTRIDE(2), .pPAD_VALUE(8'h80))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int tests = 0;
  int fails = 0;

  logic [23:0]  frame[$];
  logic [23:0]  pix_q[$];
  logic [215:0] exp_q[$];
  logic [215:0] got_win[$];
  int           got_row[$];
  int           got_col[$];
  logic [215:0] kat [4];
  int           done_cnt;
  int           acc_cnt;
  int           acc_at_stall;

  logic         s_in_ready, s_out_valid, s_done;
  logic [215:0] s_win;
  int           s_row, s_col;

  task automatic chk(input string tag, input logic [215:0] obs, input logic [215:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [23:0] d, input logic r);
    if (sel == 0) begin
      ifa.in_valid = v; ifa.in_data = d[7:0]; ifa.out_ready = r;
    end else begin
      ifb.in_valid = v; ifb.in_data = d; ifb.out_ready = r;
    end
  endtask

  task automatic sample(input int sel);
    s_win = '0;
    if (sel == 0) begin
      s_in_ready = ifa.in_ready; s_out_valid = ifa.out_valid; s_done = ifa.done;
      s_win[71:0] = ifa.out_window; s_row = int'(ifa.out_row); s_col = int'(ifa.out_col);
    end else begin
      s_in_ready = ifb.in_ready; s_out_valid = ifb.out_valid; s_done = ifb.done;
      s_win = ifb.out_window; s_row = int'(ifb.out_row); s_col = int'(ifb.out_col);
    end
  endtask

  // Reference: element (ky,kx) of window (oy,ox) is input pixel (2*oy-1+ky, 2*ox-1+kx) or the pad pixel.
  task automatic build_exp(input int sel);
    int w, c, ow, y, x, e;
    logic [7:0]   pad;
    logic [23:0]  px;
    logic [215:0] win;
    w   = (sel == 0) ? 4 : 8;
    c   = (sel == 0) ? 1 : 3;
    pad = (sel == 0) ? 8'h00 : 8'h80;
    ow  = (w - 3 + 2) / 2 + 1;
    exp_q.delete();
    for (int oy = 0; oy < ow; oy++)
      for (int ox = 0; ox < ow; ox++) begin
        win = '0;
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            y = oy * 2 - 1 + ky;
            x = ox * 2 - 1 + kx;
            e = ky * 3 + kx;
            if (y >= 0 && y < w && x >= 0 && x < w) px = frame[y * w + x];
            else px = {pad, pad, pad};
            for (int ch = 0; ch < c; ch++) win[(e * c + ch) * 8 +: 8] = px[ch * 8 +: 8];
          end
        exp_q.push_back(win);
      end
  endtask

  task automatic new_frame(input int sel, input bit ramp);
    int n;
    n = (sel == 0) ? 16 : 64;
    frame.delete();
    for (int i = 0; i < n; i++) begin
      if (ramp) frame.push_back(24'(i + 1));
      else if (sel == 0) frame.push_back({16'h0, 8'($urandom)});
      else frame.push_back(24'($urandom));
    end
    build_exp(sel);
  endtask

  // mode 0: out_ready=1; 1: hold out_ready low for the first hold_n presented cycles;
  // 2: hold out_ready low until input has stalled 5 cycles; 3: random out_ready.
  task automatic run(input int sel, input int frames, input int mode, input int hold_n, input int budget);
    int   n, pres, low_run, last_fire;
    logic rdy, v;
    n = 0; pres = 0; low_run = 0; last_fire = -10;
    done_cnt = 0; acc_cnt = 0; acc_at_stall = -1;
    got_win.delete(); got_row.delete(); got_col.delete();
    while (done_cnt < frames && n < budget) begin
      @(negedge clk);
      case (mode)
        1:       rdy = (pres >= hold_n);
        2:       rdy = (acc_at_stall >= 0);
        3:       rdy = ($urandom_range(0, 1) == 1);
        default: rdy = 1'b1;
      endcase
      v = (pix_q.size() > 0);
      drive(sel, v, v ? pix_q[0] : 24'h0, rdy);
      #1;
      sample(sel);
      if (mode == 1 && s_out_valid && !rdy) begin
        chk("stall_window", s_win, exp_q[0]);
        chki("stall_row", s_row, 0);
        chki("stall_col", s_col, 0);
      end
      if (v && !s_in_ready) low_run++;
      else low_run = 0;
      if (low_run == 5 && acc_at_stall < 0) acc_at_stall = acc_cnt;
      if (v && s_in_ready) begin
        void'(pix_q.pop_front());
        acc_cnt++;
      end
      if (s_out_valid) pres++;
      if (s_out_valid && rdy) begin
        got_win.push_back(s_win);
        got_row.push_back(s_row);
        got_col.push_back(s_col);
        last_fire = n;
      end
      if (s_done) begin
        done_cnt++;
        chki("done_after_last_transfer", n, last_fire + 1);
      end
      n++;
    end
    chki("run_within_budget", int'(n < budget), 1);
    @(negedge clk);
    drive(sel, 1'b0, 24'h0, 1'b1);
  endtask

  task automatic idle_check(input int sel);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(sel, 1'b0, 24'h0, 1'b1);
      #1;
      sample(sel);
      chki("idle_no_done", int'(s_done), 0);
      chki("idle_no_valid", int'(s_out_valid), 0);
    end
    chki("idle_in_ready", int'(s_in_ready), 1);
  endtask

  task automatic check_windows(input int sel, input int nwin, input bit use_kat);
    int ow;
    ow = (sel == 0) ? 2 : 4;
    chki("window_count", got_win.size(), nwin);
    for (int i = 0; i < nwin && i < got_win.size(); i++) begin
      if (use_kat) chk("kat_window", got_win[i], kat[i % 4]);
      else chk("model_window", got_win[i], exp_q[i % exp_q.size()]);
      chki("out_row", got_row[i], (i % (ow * ow)) / ow);
      chki("out_col", got_col[i], i % ow);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 1'b0, 24'h0, 1'b0);
    drive(1, 1'b0, 24'h0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s);
      chki("rst_in_ready", int'(s_in_ready), 0);
      chki("rst_out_valid", int'(s_out_valid), 0);
      chk("rst_out_window", s_win, 216'h0);
      chki("rst_out_row", s_row, 0);
      chki("rst_out_col", s_col, 0);
      chki("rst_done", int'(s_done), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    sample(0);
    chki("post_rst_in_ready_a", int'(s_in_ready), 1);
    sample(1);
    chki("post_rst_in_ready_b", int'(s_in_ready), 1);
  endtask

  initial begin
    kat[0] = 216'h06_05_00_02_01_00_00_00_00;
    kat[1] = 216'h08_07_06_04_03_02_00_00_00;
    kat[2] = 216'h0e_0d_00_0a_09_00_06_05_00;
    kat[3] = 216'h10_0f_0e_0c_0b_0a_08_07_06;

    do_reset();

    // 4x4 ramp frame, consumer always ready
    new_frame(0, 1'b1);
    pix_q = frame;
    run(0, 1, 0, 0, 400);
    check_windows(0, 4, 1'b1);
    chki("done_count_single", done_cnt, 1);
    idle_check(0);

    // consumer stalls 20 cycles on the first window
    new_frame(0, 1'b1);
    pix_q = frame;
    run(0, 1, 1, 20, 400);
    check_windows(0, 4, 1'b1);

    // two back-to-back frames with in_valid held high
    new_frame(0, 1'b1);
    pix_q = frame;
    foreach (frame[i]) pix_q.push_back(frame[i]);
    run(0, 2, 0, 0, 600);
    check_windows(0, 8, 1'b1);
    chki("done_count_b2b", done_cnt, 2);

    // reset after 7 pixels of a frame, then a clean ramp frame
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(0, 1'b1, 24'($urandom), 1'b1);
      #1;
      sample(0);
      chki("partial_in_ready", int'(s_in_ready), 1);
    end
    do_reset();
    new_frame(0, 1'b1);
    pix_q = frame;
    run(0, 1, 0, 0, 400);
    check_windows(0, 4, 1'b1);

    // 8x8, 3 channels, pad 0x80: consumer blocked until input stalls
    new_frame(1, 1'b0);
    pix_q = frame;
    run(1, 1, 2, 0, 1500);
    chki("backpressure_accepted", acc_at_stall, 40);
    check_windows(1, 16, 1'b0);
    if (got_win.size() > 0) chk("pad_pixel_c3", {192'h0, got_win[0][23:0]}, 216'h808080);
    if (got_win.size() == 16) chk("window_3_3_elem0", {192'h0, got_win[15][23:0]}, {192'h0, frame[5 * 8 + 5]});
    idle_check(1);

    // 8x8 random data with random consumer readiness
    new_frame(1, 1'b0);
    pix_q = frame;
    run(1, 1, 3, 0, 3000);
    check_windows(1, 16, 1'b0);
    chki("done_count_random", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
